// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with runtime frame format and valid/ready output.
// Define UART_RX_OS_BREAK_DET_EN to add break detection (BREAKo port, BRK_WAIT state).
module uart_rx_os #(
    parameter int FREQ_CLK  = 100000000,
    parameter int DEF_BAUD  = 115200,
    parameter int DATA_WDTH = 9,
    parameter int OVS       = 16,
    parameter int DIV_WDTH  = 16
) (
    input  logic                 CLKip,
    input  logic                 RSTNi,
    input  logic                 RXi,
    input  logic                 CFG_WEi,
    input  logic [DIV_WDTH-1:0]  DIVi,
    input  logic [3:0]           NBITSi,
    input  logic                 PAR_ENi,
    input  logic                 PAR_ODDi,
    input  logic                 STOP2i,
    input  logic                 READYi,
    output logic [DATA_WDTH-1:0] DATAo,
    output logic                 VALIDo,
    output logic                 PAR_ERRo,
    output logic                 FRAME_ERRo,
    output logic                 OVR_ERRo,
`ifdef UART_RX_OS_BREAK_DET_EN
    output logic                 BREAKo,
`endif
    output logic                 BUSYo
);

    localparam int OW = $clog2(OVS);
    localparam logic [DIV_WDTH-1:0] DEF_DIV = DIV_WDTH'(FREQ_CLK / (DEF_BAUD * OVS));
    localparam logic [OW-1:0] MID  = OW'(OVS / 2);
    localparam logic [OW-1:0] LAST = OW'(OVS - 1);
    localparam logic [3:0] NMAX = 4'(DATA_WDTH);
    localparam logic [3:0] NDEF = (DATA_WDTH < 8) ? 4'(DATA_WDTH) : 4'd8;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
`ifdef UART_RX_OS_BREAK_DET_EN
        , BRK_WAIT
`endif
    } state_t;

    state_t state;

    logic                 rx_s1, rx_s2, rx_d;
    logic [DIV_WDTH-1:0]  div_q, div_eff, div_last, div_cnt;
    logic [3:0]           nbits_q, nbits_in, bit_cnt;
    logic                 par_en_q, par_odd_q, stop2_q;
    logic                 tick, start_det, vote, at_mid;
    logic [1:0]           samp;
    logic [OW-1:0]        os_cnt;
    logic [DATA_WDTH-1:0] shreg;
    logic                 par_acc, zero_l, par_err_l, frm_err_l, stop_cnt;

    always_ff @(posedge CLKip or negedge RSTNi) begin
        if (!RSTNi) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= RXi;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    always_comb begin
        nbits_in = NBITSi;
        if (NBITSi < 4'd5)
            nbits_in = 4'd5;
        else if (NBITSi > NMAX)
            nbits_in = NMAX;
    end

    always_ff @(posedge CLKip or negedge RSTNi) begin
        if (!RSTNi) begin
            div_q     <= DEF_DIV;
            nbits_q   <= NDEF;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else if (CFG_WEi && state == IDLE) begin
            div_q     <= DIVi;
            nbits_q   <= nbits_in;
            par_en_q  <= PAR_ENi;
            par_odd_q <= PAR_ODDi;
            stop2_q   <= STOP2i;
        end
    end

    assign div_eff   = (div_q == '0) ? DIV_WDTH'(1) : div_q;
    assign div_last  = div_eff - DIV_WDTH'(1);
    assign tick      = (div_cnt == div_last);
    assign start_det = (state == IDLE) && rx_d && !rx_s2;

    always_ff @(posedge CLKip or negedge RSTNi) begin
        if (!RSTNi)
            div_cnt <= '0;
        else if (start_det || div_cnt >= div_last)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_WDTH'(1);
    end

    always_ff @(posedge CLKip or negedge RSTNi) begin
        if (!RSTNi)
            samp <= 2'b11;
        else if (tick)
            samp <= {samp[0], rx_s2};
    end

    // Ticks count from 1 at START entry; votes use ticks OVS/2-1..OVS/2+1.
    assign vote   = (samp[1] & samp[0]) | (samp[1] & rx_s2) | (samp[0] & rx_s2);
    assign at_mid = tick && (os_cnt == MID);
    assign BUSYo  = (state != IDLE);

    always_ff @(posedge CLKip or negedge RSTNi) begin
        if (!RSTNi) begin
            state      <= IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            zero_l     <= 1'b0;
            par_err_l  <= 1'b0;
            frm_err_l  <= 1'b0;
            stop_cnt   <= 1'b0;
            DATAo      <= '0;
            VALIDo     <= 1'b0;
            PAR_ERRo   <= 1'b0;
            FRAME_ERRo <= 1'b0;
            OVR_ERRo   <= 1'b0;
`ifdef UART_RX_OS_BREAK_DET_EN
            BREAKo     <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_OS_BREAK_DET_EN
            BREAKo <= 1'b0;
`endif
            if (VALIDo && READYi) begin
                VALIDo   <= 1'b0;
                OVR_ERRo <= 1'b0;
            end
            if (tick && state != IDLE)
                os_cnt <= (os_cnt == LAST) ? '0 : os_cnt + OW'(1);
            unique case (state)
                IDLE: if (start_det) begin
                    state     <= START;
                    os_cnt    <= '0;
                    bit_cnt   <= '0;
                    shreg     <= '0;
                    par_acc   <= 1'b0;
                    zero_l    <= 1'b1;
                    par_err_l <= 1'b0;
                    frm_err_l <= 1'b0;
                    stop_cnt  <= 1'b0;
                end
                START: if (at_mid)
                    state <= vote ? IDLE : DATA;
                DATA: if (at_mid) begin
                    shreg   <= shreg | ({{(DATA_WDTH-1){1'b0}}, vote} << bit_cnt);
                    par_acc <= par_acc ^ vote;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (vote)
                        zero_l <= 1'b0;
                    if (bit_cnt == nbits_q - 4'd1)
                        state <= par_en_q ? PARITY : STOP;
                end
                PARITY: if (at_mid) begin
                    if ((par_acc ^ vote) != par_odd_q)
                        par_err_l <= 1'b1;
                    if (vote)
                        zero_l <= 1'b0;
                    state <= STOP;
                end
                STOP: if (at_mid) begin
`ifdef UART_RX_OS_BREAK_DET_EN
                    if (!stop_cnt && !vote && zero_l) begin
                        BREAKo <= 1'b1;
                        state  <= BRK_WAIT;
                        os_cnt <= '0;
                    end else
`endif
                    if (stop2_q && !stop_cnt) begin
                        stop_cnt <= 1'b1;
                        if (!vote)
                            frm_err_l <= 1'b1;
                    end else begin
                        state <= IDLE;
                        if (!VALIDo || READYi) begin
                            DATAo      <= shreg;
                            VALIDo     <= 1'b1;
                            PAR_ERRo   <= par_err_l;
                            FRAME_ERRo <= frm_err_l | !vote;
                        end else begin
                            OVR_ERRo <= 1'b1;
                        end
                    end
                end
`ifdef UART_RX_OS_BREAK_DET_EN
                // Line must stay high for OVS consecutive ticks before rearming.
                BRK_WAIT: if (tick) begin
                    if (!rx_s2)
                        os_cnt <= '0;
                    else if (os_cnt == LAST)
                        state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed frames against uart_rx_os with hand-computed results.
// Honours UART_RX_OS_BREAK_DET_EN for the break case.
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       RSTNi, RXi, CFG_WEi, PAR_ENi, PAR_ODDi, STOP2i, READYi;
    logic [15:0] DIVi;
    logic [3:0] NBITSi;
    logic [8:0] DATAo;
    logic       VALIDo, PAR_ERRo, FRAME_ERRo, OVR_ERRo, BUSYo;
`ifdef UART_RX_OS_BREAK_DET_EN
    logic       BREAKo;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int bp = 864;
    int got_cnt = 0;
    int vcyc = 0;
    int brk_cnt = 0;
    int ecnt = 0;
    logic [8:0] got_data = '0;
    logic got_pe = 1'b0;
    logic got_fe = 1'b0;
    logic v_prev = 1'b0;

    uart_rx_os dut (
        .CLKip(clk), .RSTNi(RSTNi), .RXi(RXi), .CFG_WEi(CFG_WEi),
        .DIVi(DIVi), .NBITSi(NBITSi), .PAR_ENi(PAR_ENi),
        .PAR_ODDi(PAR_ODDi), .STOP2i(STOP2i), .READYi(READYi),
        .DATAo(DATAo), .VALIDo(VALIDo), .PAR_ERRo(PAR_ERRo),
        .FRAME_ERRo(FRAME_ERRo), .OVR_ERRo(OVR_ERRo),
`ifdef UART_RX_OS_BREAK_DET_EN
        .BREAKo(BREAKo),
`endif
        .BUSYo(BUSYo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (VALIDo && !v_prev) begin
            got_cnt++;
            got_data = DATAo;
            got_pe = PAR_ERRo;
            got_fe = FRAME_ERRo;
        end
        v_prev = VALIDo;
        if (VALIDo)
            vcyc++;
`ifdef UART_RX_OS_BREAK_DET_EN
        if (BREAKo)
            brk_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input int dv, input int nb, input logic pe,
                       input logic po, input logic s2);
        @(negedge clk);
        DIVi = 16'(dv);
        NBITSi = 4'(nb);
        PAR_ENi = pe;
        PAR_ODDi = po;
        STOP2i = s2;
        CFG_WEi = 1'b1;
        @(negedge clk);
        CFG_WEi = 1'b0;
    endtask

    // par < 0: no parity bit; gb: index of bit given a mid-bit glitch
    task automatic send(input logic [8:0] d, input int nb, input int par,
                        input logic stp, input int ns, input int gb);
        logic seq [0:13];
        int n;
        seq[0] = 1'b0;
        n = 1;
        for (int i = 0; i < nb; i++) begin
            seq[n] = d[i];
            n++;
        end
        if (par >= 0) begin
            seq[n] = par[0];
            n++;
        end
        seq[n] = stp;
        n++;
        if (ns == 2) begin
            seq[n] = 1'b1;
            n++;
        end
        @(negedge clk);
        for (int j = 0; j < n; j++)
            for (int c = 0; c < bp; c++) begin
                if (j == gb && c >= bp/2 - 1 && c <= bp/2 + 1)
                    RXi = ~seq[j];
                else
                    RXi = seq[j];
                @(negedge clk);
            end
        RXi = 1'b1;
    endtask

    task automatic word(input string tag, input logic [8:0] d,
                        input logic pe, input logic fe);
        chk({tag, "_cnt"}, got_cnt, ecnt);
        chk({tag, "_data"}, got_data, d);
        chk({tag, "_pe"}, got_pe, pe);
        chk({tag, "_fe"}, got_fe, fe);
    endtask

    initial begin
        RSTNi = 1'b0;
        RXi = 1'b1;
        CFG_WEi = 1'b0;
        DIVi = '0;
        NBITSi = 4'd8;
        PAR_ENi = 1'b0;
        PAR_ODDi = 1'b0;
        STOP2i = 1'b0;
        READYi = 1'b1;
        idle(3);
        RSTNi = 1'b1;
        idle(2);
        chk("rst_data", DATAo, 0);
        chk("rst_valid", VALIDo, 0);
        chk("rst_pe", PAR_ERRo, 0);
        chk("rst_fe", FRAME_ERRo, 0);
        chk("rst_ovr", OVR_ERRo, 0);
        chk("rst_busy", BUSYo, 0);
`ifdef UART_RX_OS_BREAK_DET_EN
        chk("rst_brk", BREAKo, 0);
`endif

        // reset divisor 54, 8N1
        bp = 864;
        vcyc = 0;
        send(9'hA5, 8, -1, 1'b1, 1, -1);
        idle(20);
        ecnt++;
        word("a5", 9'hA5, 0, 0);
        chk("a5_vcyc", vcyc, 1);
        chk("a5_busy", BUSYo, 0);
        chk("a5_ovr", OVR_ERRo, 0);

        // 7E2 at DIV=4
        cfg(4, 7, 1'b1, 1'b0, 1'b1);
        bp = 64;
        send(9'h41, 7, 0, 1'b1, 2, -1);
        ecnt++;
        word("p_ok", 9'h41, 0, 0);
        send(9'h41, 7, 1, 1'b1, 2, -1);
        ecnt++;
        word("p_bad", 9'h41, 1, 0);

        // false start
        cfg(4, 8, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        RXi = 1'b0;
        idle(19);
        RXi = 1'b1;
        chk("fs_busy_mid", BUSYo, 1);
        idle(128);
        chk("fs_busy", BUSYo, 0);
        chk("fs_cnt", got_cnt, ecnt);
        chk("fs_valid", VALIDo, 0);

        // glitch on data bit 3 (a 0 bit)
        send(9'h55, 8, -1, 1'b1, 1, 4);
        ecnt++;
        word("glitch", 9'h55, 0, 0);

        // overrun
        READYi = 1'b0;
        send(9'h11, 8, -1, 1'b1, 1, -1);
        ecnt++;
        chk("ovr_v1", VALIDo, 1);
        send(9'h22, 8, -1, 1'b1, 1, -1);
        chk("ovr_data", DATAo, 9'h11);
        chk("ovr_flag", OVR_ERRo, 1);
        chk("ovr_valid", VALIDo, 1);
        chk("ovr_cnt", got_cnt, ecnt);
        READYi = 1'b1;
        idle(1);
        chk("ovr_acc_v", VALIDo, 0);
        chk("ovr_acc_o", OVR_ERRo, 0);

        // stop bit low
        send(9'h3C, 8, -1, 1'b0, 1, -1);
        ecnt++;
        word("ferr", 9'h3C, 0, 1);

        // break frame
        send(9'h00, 8, -1, 1'b0, 1, -1);
`ifdef UART_RX_OS_BREAK_DET_EN
        chk("brk_pulse", brk_cnt, 1);
        chk("brk_busy", BUSYo, 1);
        chk("brk_cnt", got_cnt, ecnt);
        idle(100);
        chk("brk_rec", BUSYo, 0);
`else
        ecnt++;
        word("brk", 9'h00, 0, 1);
`endif
        send(9'hC3, 8, -1, 1'b1, 1, -1);
        ecnt++;
        word("after_brk", 9'hC3, 0, 0);

        // config write during a frame
        fork
            send(9'h5A, 8, -1, 1'b1, 1, -1);
            begin
                idle(200);
                DIVi = 16'd9;
                NBITSi = 4'd5;
                CFG_WEi = 1'b1;
                idle(1);
                CFG_WEi = 1'b0;
                DIVi = 16'd4;
                NBITSi = 4'd8;
            end
        join
        ecnt++;
        word("cfg_busy", 9'h5A, 0, 0);
        send(9'h81, 8, -1, 1'b1, 1, -1);
        ecnt++;
        word("cfg_keep", 9'h81, 0, 0);

        // DIV=0 acts as 1; NBITS clamped to 9 and to 5
        cfg(0, 15, 1'b0, 1'b0, 1'b0);
        bp = 16;
        send(9'h1A5, 9, -1, 1'b1, 1, -1);
        ecnt++;
        word("n9", 9'h1A5, 0, 0);
        cfg(0, 2, 1'b0, 1'b0, 1'b0);
        send(9'h015, 5, -1, 1'b1, 1, -1);
        ecnt++;
        word("n5", 9'h015, 0, 0);

        // reset mid-DATA
        cfg(4, 8, 1'b0, 1'b0, 1'b0);
        bp = 64;
        @(negedge clk);
        RXi = 1'b0;
        idle(64 * 3);
        RXi = 1'b1;
        idle(20);
        chk("mid_busy", BUSYo, 1);
        RSTNi = 1'b0;
        idle(2);
        chk("mid_rst_busy", BUSYo, 0);
        chk("mid_rst_valid", VALIDo, 0);
        RSTNi = 1'b1;
        idle(700);
        chk("mid_cnt", got_cnt, ecnt);
        cfg(4, 8, 1'b0, 1'b0, 1'b0);
        send(9'h96, 8, -1, 1'b1, 1, -1);
        ecnt++;
        word("post_rst", 9'h96, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
